// File: rtl/contador_ud_param_if.sv
// Control/status bundle for contador_ud_param: count controls in, count/direction/event out.
// WIDTH here must match the WIDTH of the counter it is connected to.
interface contador_ud_param_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic [1:0]       mode;
   logic             ld;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] saida;
   logic             dir;
   logic             evt;

   modport master (
      output en, mode, ld, ld_val,
      input  saida, dir, evt
   );

   modport slave (
      input  en, mode, ld, ld_val,
      output saida, dir, evt
   );
endinterface

// File: rtl/contador_ud_param.sv
// Parameterised up/down/bounce counter bounded to [MIN,MAX], with clamped load and a
// one-cycle event pulse on every wrap or turn-around. All outputs are registered.
//
// state | meaning
// UP    | counting toward MAX (also the direction after reset and in up-wrap)
// DOWN  | counting toward MIN (down-wrap, or bounce after turning at MAX)
module contador_ud_param #(
   parameter int WIDTH = 4,
   parameter int MIN   = 0,
   parameter int MAX   = 15
) (
   input logic                clk,
   input logic                clr,
   contador_ud_param_if.slave bus
);

   if (!(MIN >= 0 && MIN < MAX && longint'(MAX) <= (longint'(1) << WIDTH) - 1)) begin : g_bad_params
      $error("contador_ud_param: illegal parameters WIDTH=%0d MIN=%0d MAX=%0d", WIDTH, MIN, MAX);
   end

   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

   localparam logic [1:0] M_UP     = 2'b00;
   localparam logic [1:0] M_DOWN   = 2'b01;
   localparam logic [1:0] M_BOUNCE = 2'b10;

   typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

   logic [WIDTH-1:0] cnt_q, cnt_n, ld_clamped;
   dir_t             dir_q, dir_n;
   logic             evt_q, evt_n;

   always_comb begin
      ld_clamped = bus.ld_val;
      if (bus.ld_val < MIN_V)
         ld_clamped = MIN_V;
      else if (bus.ld_val > MAX_V)
         ld_clamped = MAX_V;
   end

   // Next-state selection below clr: load, then enabled counting, otherwise hold.
   always_comb begin
      cnt_n = cnt_q;
      dir_n = dir_q;
      evt_n = 1'b0;
      if (bus.ld) begin
         cnt_n = ld_clamped;
      end else if (bus.en) begin
         case (bus.mode)
            M_UP: begin
               dir_n = UP;
               if (cnt_q == MAX_V) begin
                  cnt_n = MIN_V;
                  evt_n = 1'b1;
               end else begin
                  cnt_n = cnt_q + ONE_V;
               end
            end
            M_DOWN: begin
               dir_n = DOWN;
               if (cnt_q == MIN_V) begin
                  cnt_n = MAX_V;
                  evt_n = 1'b1;
               end else begin
                  cnt_n = cnt_q - ONE_V;
               end
            end
            M_BOUNCE: begin
               // Turn-around steps straight off the bound so each bound is held one cycle only.
               if (dir_q == UP) begin
                  if (cnt_q == MAX_V) begin
                     cnt_n = MAX_V - ONE_V;
                     dir_n = DOWN;
                     evt_n = 1'b1;
                  end else begin
                     cnt_n = cnt_q + ONE_V;
                  end
               end else begin
                  if (cnt_q == MIN_V) begin
                     cnt_n = MIN_V + ONE_V;
                     dir_n = UP;
                     evt_n = 1'b1;
                  end else begin
                     cnt_n = cnt_q - ONE_V;
                  end
               end
            end
            default: begin
               cnt_n = cnt_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         cnt_q <= MIN_V;
         dir_q <= UP;
         evt_q <= 1'b0;
      end else begin
         cnt_q <= cnt_n;
         dir_q <= dir_n;
         evt_q <= evt_n;
      end
   end

   assign bus.saida = cnt_q;
   assign bus.dir   = dir_q;
   assign bus.evt   = evt_q;

endmodule

// File: tb/tb_contador_ud_param.sv
// Bench for contador_ud_param: three instances (default, offset bounds, 2-value bounce)
// driven in lockstep and compared against a phase-based reference model.
module tb_contador_ud_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr_s = 1'b0;
   logic       en_s = 1'b0;
   logic [1:0] mode_s = 2'b11;
   logic       ld_s = 1'b0;
   logic [3:0] ldv_s = 4'd0;

   contador_ud_param_if #(.WIDTH(4)) ifa ();
   contador_ud_param_if #(.WIDTH(4)) ifb ();
   contador_ud_param_if #(.WIDTH(1)) ifc ();

   assign ifa.en = en_s;  assign ifa.mode = mode_s;  assign ifa.ld = ld_s;  assign ifa.ld_val = ldv_s;
   assign ifb.en = en_s;  assign ifb.mode = mode_s;  assign ifb.ld = ld_s;  assign ifb.ld_val = ldv_s;
   assign ifc.en = en_s;  assign ifc.mode = mode_s;  assign ifc.ld = ld_s;  assign ifc.ld_val = ldv_s[0];

   contador_ud_param #(.WIDTH(4), .MIN(0), .MAX(15)) dut_a (.clk(clk), .clr(clr_s), .bus(ifa));
   contador_ud_param #(.WIDTH(4), .MIN(3), .MAX(10)) dut_b (.clk(clk), .clr(clr_s), .bus(ifb));
   contador_ud_param #(.WIDTH(1), .MIN(0), .MAX(1))  dut_c (.clk(clk), .clr(clr_s), .bus(ifc));

   int total = 0;
   int bad = 0;

   int mn [3] = '{0, 3, 0};
   int mx [3] = '{15, 10, 1};
   int m_cnt [3];
   int m_dir [3];
   int m_evt [3];

   // Reference: wraps as modular arithmetic, bounce as a position on a triangle wave
   // of period 2*(MAX-MIN); a turn is any bounce step whose direction differs from before.
   task automatic model_step(int i);
      int span, r, p, p2, v, nd;
      span = mx[i] - mn[i] + 1;
      r    = mx[i] - mn[i];
      v    = (i == 2) ? int'(ldv_s[0]) : int'(ldv_s);
      if (!clr_s) begin
         m_cnt[i] = mn[i]; m_dir[i] = 0; m_evt[i] = 0;
      end else if (ld_s) begin
         m_cnt[i] = (v < mn[i]) ? mn[i] : (v > mx[i]) ? mx[i] : v;
         m_evt[i] = 0;
      end else if (!en_s || mode_s == 2'b11) begin
         m_evt[i] = 0;
      end else if (mode_s == 2'b00) begin
         m_evt[i] = (m_cnt[i] == mx[i]) ? 1 : 0;
         m_cnt[i] = mn[i] + (m_cnt[i] - mn[i] + 1) % span;
         m_dir[i] = 0;
      end else if (mode_s == 2'b01) begin
         m_evt[i] = (m_cnt[i] == mn[i]) ? 1 : 0;
         m_cnt[i] = mn[i] + (m_cnt[i] - mn[i] - 1 + span) % span;
         m_dir[i] = 1;
      end else begin
         p  = (m_dir[i] != 0) ? (2 * r - (m_cnt[i] - mn[i])) % (2 * r) : (m_cnt[i] - mn[i]);
         p2 = (p + 1) % (2 * r);
         m_cnt[i] = (p2 <= r) ? mn[i] + p2 : mn[i] + 2 * r - p2;
         nd = (p2 > r || p2 == 0) ? 1 : 0;
         m_evt[i] = (nd != m_dir[i]) ? 1 : 0;
         m_dir[i] = nd;
      end
   endtask

   task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(string tag);
      logic [3:0] ms, md, me;
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      #1;
      for (int i = 0; i < 3; i++) begin
         ms = 4'(m_cnt[i]); md = 4'(m_dir[i]); me = 4'(m_evt[i]);
         case (i)
            0: begin
               chk($sformatf("%s.a.saida", tag), ifa.saida, ms);
               chk($sformatf("%s.a.dir", tag), {3'b0, ifa.dir}, md);
               chk($sformatf("%s.a.evt", tag), {3'b0, ifa.evt}, me);
            end
            1: begin
               chk($sformatf("%s.b.saida", tag), ifb.saida, ms);
               chk($sformatf("%s.b.dir", tag), {3'b0, ifb.dir}, md);
               chk($sformatf("%s.b.evt", tag), {3'b0, ifb.evt}, me);
            end
            default: begin
               chk($sformatf("%s.c.saida", tag), {3'b0, ifc.saida}, ms);
               chk($sformatf("%s.c.dir", tag), {3'b0, ifc.dir}, md);
               chk($sformatf("%s.c.evt", tag), {3'b0, ifc.evt}, me);
            end
         endcase
      end
   endtask

   initial begin
      int evt_cnt;

      // Reset with load and enable active: clr must win.
      clr_s = 1'b0; ld_s = 1'b1; ldv_s = 4'd9; en_s = 1'b1; mode_s = 2'b10;
      tick("reset");
      chk("reset.a.const", ifa.saida, 4'd0);

      // Free-running bounce from reset, 32 edges on the default instance.
      clr_s = 1'b1; ld_s = 1'b0;
      evt_cnt = 0;
      for (int k = 0; k < 32; k++) begin
         tick("bounce32");
         if (ifa.evt === 1'b1) evt_cnt++;
      end
      chk("bounce32.a.end", ifa.saida, 4'd2);
      chk("bounce32.a.evts", 4'(evt_cnt), 4'd2);

      // Up-wrap from MAX, then down-wrap from MIN.
      ld_s = 1'b1; ldv_s = 4'd15; tick("ld15");
      ld_s = 1'b0; mode_s = 2'b00; tick("upwrap");
      chk("upwrap.a.const", ifa.saida, 4'd0);
      chk("upwrap.a.evt", {3'b0, ifa.evt}, 4'd1);
      mode_s = 2'b01; tick("downwrap");
      chk("downwrap.a.const", ifa.saida, 4'd15);
      chk("downwrap.a.dir", {3'b0, ifa.dir}, 4'd1);

      // Clamped loads; load beats enable.
      ld_s = 1'b1; ldv_s = 4'd12; tick("ld12");
      chk("ld12.b.clamp", ifb.saida, 4'd10);
      ldv_s = 4'd1; tick("ld1");
      chk("ld1.b.clamp", ifb.saida, 4'd3);

      // Bounce going down at 7, switch to up-wrap, then freeze in mode 11.
      ldv_s = 4'd7; mode_s = 2'b10; tick("ld7");
      ld_s = 1'b0; mode_s = 2'b00; tick("to_up");
      chk("to_up.a.const", ifa.saida, 4'd8);
      chk("to_up.a.dir", {3'b0, ifa.dir}, 4'd0);
      mode_s = 2'b11;
      for (int k = 0; k < 3; k++) tick("hold");
      en_s = 1'b0; mode_s = 2'b01;
      for (int k = 0; k < 2; k++) tick("en0");

      // Reset in the middle of a bounce turn, then resume from MIN.
      en_s = 1'b1; ld_s = 1'b1; ldv_s = 4'd14; mode_s = 2'b00; tick("ld14");
      ld_s = 1'b0; mode_s = 2'b10; tick("to15");
      chk("to15.a.const", ifa.saida, 4'd15);
      clr_s = 1'b0; tick("midclr");
      clr_s = 1'b1; tick("resume");
      chk("resume.a.const", ifa.saida, 4'd1);

      // Two-value bounce turns every enabled cycle.
      for (int k = 0; k < 6; k++) tick("minmax");

      // Randomised traffic.
      for (int k = 0; k < 600; k++) begin
         clr_s  = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
         ld_s   = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
         en_s   = ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0;
         mode_s = 2'($urandom_range(0, 3));
         ldv_s  = 4'($urandom_range(0, 15));
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/contador_ud_param.md
CONTADOR_UD_PARAM -- requirements
Module: contador_ud_param

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter MIN, default 0, lower count bound.
REQ-003 Parameter MAX, default 15, upper count bound.
REQ-004 Parameter legality: MIN < MAX <= 2^WIDTH-1; elaboration SHALL fail otherwise.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 clr  input  1  reset, synchronous, active-low.
REQ-007 en  input  1  count enable; 0 holds count and dir.
REQ-008 mode  input  2  00 up-wrap, 01 down-wrap, 10 bounce (up/down ping-pong), 11 hold.
REQ-009 ld  input  1  synchronous load strobe.
REQ-010 ld_val  input  WIDTH  load value.
REQ-011 saida  output  WIDTH  current count, registered.
REQ-012 dir  output  1  current direction, registered; 0 up, 1 down.
REQ-013 evt  output  1  registered one-cycle pulse on wrap or turn-around.

Function
REQ-014 Priority per edge SHALL be: clr low > ld > (en and mode) > hold.
REQ-015 ld=1: saida <= ld_val clamped to [MIN,MAX] (below MIN -> MIN, above MAX -> MAX); dir unchanged; evt <= 0; en ignored.
REQ-016 en=0 or mode=11 (no ld): saida and dir hold; evt <= 0.
REQ-017 mode=00, en=1: saida < MAX -> saida+1, evt <= 0; saida == MAX -> MIN, evt <= 1; dir <= 0.
REQ-018 mode=01, en=1: saida > MIN -> saida-1, evt <= 0; saida == MIN -> MAX, evt <= 1; dir <= 1.
REQ-019 mode=10, en=1, dir=0: saida < MAX -> saida+1; saida == MAX -> saida <= MAX-1, dir <= 1, evt <= 1.
REQ-020 mode=10, en=1, dir=1: saida > MIN -> saida-1; saida == MIN -> saida <= MIN+1, dir <= 0, evt <= 1.
REQ-021 Bounce has no dwell: each bound value appears for exactly one enabled cycle per period; period = 2*(MAX-MIN) enabled cycles.
REQ-022 Entering mode 10 from another mode SHALL keep current dir; first step uses it (REQ-019/020 apply at bounds immediately).
REQ-023 Leaving mode 10 for 00/01 SHALL force dir per REQ-017/018 on the first enabled edge; mode 11 keeps dir.
REQ-024 Mode change takes effect on the same edge it is sampled; no pipeline delay.
REQ-025 Latency: saida, dir, evt reflect inputs sampled at edge N after edge N; no combinational input-to-output path.
REQ-026 evt is asserted only on the edge performing a wrap or turn; never for two consecutive cycles unless MAX == MIN+1 in bounce (alternating turns every enabled cycle), or wrap occurs on consecutive enabled cycles (impossible for MAX > MIN).
REQ-027 saida SHALL never leave [MIN,MAX] after reset; arithmetic in WIDTH bits with no overflow reachable.

Reset
REQ-028 clr low at an edge: saida <= MIN, dir <= 0, evt <= 0, regardless of ld, en, mode.
REQ-029 clr low mid-bounce or mid-load SHALL discard the operation; first edge with clr high counts from MIN with dir=0.
REQ-030 Outputs are undefined only until the first edge with clr low; no asynchronous behaviour.

Verification
REQ-031 Defaults, clr low 1 edge, mode=10, en=1, 32 edges -> saida 1..15,14..0,1,2; dir flips on edges producing 14 and 1; evt high exactly those two cycles.
REQ-032 mode=00 from saida=15 -> saida=0, evt=1, dir=0; mode=01 from saida=0 -> saida=15, evt=1, dir=1.
REQ-033 WIDTH=4, MIN=3, MAX=10: ld=1, ld_val=12 -> saida=10; ld_val=1 -> saida=3; ld=1 with en=1 -> load wins.
REQ-034 Bounce, dir=1, saida=7, switch mode=00 -> next edge saida=8, dir=0; switch to 11 -> saida and dir frozen, evt=0.
REQ-035 Bounce at saida=15 dir=0, drive clr low -> saida=0, dir=0, evt=0; release -> saida=1.
REQ-036 MIN=0, MAX=1, bounce: saida alternates 1,0,1,0; evt high every enabled cycle; dir toggles each cycle.
